mas8_seq_ctrl: RTL and testbench
================================

// Module: mas8_seq_ctrl
// PURPOSE
// Multi-cycle fetch/decode/execute sequencer for the 8-bit ALU/register-file block.
// - Fetches 16-bit instructions from program memory and drives the ALU opcode/rd/ra/c/en/din inputs.
// - Runs lw/sw through a req/ack data-memory port; steers PC for jumps using the ALU address output.
// - Sits between the memories and the ALU; rstz is shared with the ALU.
// PARAMETERS
// PC_RESET  8'h00    PC value after reset
// HALT_OP   4'b1010  opcode treated as HALT (ALU never enabled)
// CNT_W     16       width of retired-instruction counter
// PORTS
// clk         in   1      system clock
// rstz        in   1      synchronous active-low reset
// start       in   1      leave IDLE/HALTED and begin fetching at pc
// imem_req    out  1      program fetch request
// imem_addr   out  8      fetch address (= pc)
// imem_ack    in   1      fetch complete; imem_data valid this cycle
// imem_data   in   16     instruction {op[15:12], rd[11:10], ra[9:8], c[7:0]}
// dmem_req    out  1      data access request
// dmem_we     out  1      1 = store (sw), 0 = load (lw)
// dmem_addr   out  8      data address (latched ALU address)
// dmem_wdata  out  8      store data = register selected by ir.rd
// dmem_ack    in   1      access complete; dmem_rdata valid this cycle for loads
// dmem_rdata  in   8      load data
// alu_opcode  out  4      ir[15:12]
// alu_rd      out  2      ir[11:10]
// alu_ra      out  2      ir[9:8]
// alu_c       out  8      ir[7:0]
// alu_en      out  1      one-cycle ALU write enable
// alu_din     out  8      load data to ALU (= dmem_rdata)
// alu_radr    in   8      ALU address output (ra + c)
// reg_q0..3   in   8 ea   ALU register values R0..R3
// pc          out  8      program counter
// halted      out  1      high in HALTED
// illegal     out  1      sticky: opcode 1011 or 1110 decoded
// instr_cnt   out  CNT_W  retired instructions, wraps to 0
// BEHAVIOUR
// Reset (rstz=0 at posedge):
// - state=IDLE, pc=PC_RESET, ir=0, illegal=0, instr_cnt=0, maddr=0.
// - All req/en/halted outputs 0; overrides every state, including mid-handshake.
// ALU field outputs are driven continuously from ir, so alu_radr is valid in EXEC and MEM.
// States: IDLE, FETCH, EXEC, MEM, HALTED.
// - IDLE: wait; start=1 -> FETCH.
// - FETCH: imem_req=1, imem_addr=pc. On ack: ir<=imem_data, -> EXEC.
// - EXEC (1 cycle), decode ir.op:
//   - 0000-0111, 1100, 1101: alu_en=1, pc+1, cnt+1, -> FETCH.
//   - 1111 jmp: pc<=alu_radr, cnt+1, alu_en=0, -> FETCH.
//   - 1000 lw / 1001 sw: maddr<=alu_radr, -> MEM.
//   - HALT_OP: pc+1, cnt+1, -> HALTED.
//   - 1011, 1110: illegal<=1, pc+1, no alu_en, cnt unchanged, -> FETCH.
// - MEM: dmem_req=1, dmem_addr=maddr, dmem_we=(op==1001), dmem_wdata=reg_q[rd]. On ack:
//   - lw: alu_en=1 and alu_din=dmem_rdata in the ack cycle.
//   - Both lw and sw: pc+1, cnt+1, -> FETCH.
// - HALTED: halted=1, no requests; start=1 -> FETCH at current pc.
// Handshake:
// - req rises on entering the state and stays high until ack is sampled high.
// - ack with req low is ignored; req is low the cycle after ack.
// - Zero-wait ack (same cycle as req) is legal.
// Latency at zero wait: ALU op/jmp/halt = 2 cycles; lw/sw = 3 cycles.
// pc and instr_cnt wrap modulo 2^width (8'hFF+1 = 8'h00). start outside IDLE/HALTED is ignored.
// TESTING
// 1. Reset, start, imem[0]=16'h0005, ack 0-wait -> R0=8'h05 after EXEC, pc=1, instr_cnt=1.
// 2. R0=5, ir=16'hF010 -> pc=8'h15, no alu_en, next imem_addr=8'h15.
// 3. R0=5, R1=7, ir=16'h9402, ack after 3 waits -> req high 4 cycles, addr=8'h07, we=1, wdata=8'h07.
// 4. R0=5, ir=16'h8803, rdata=8'hA5 -> addr=8'h08, we=0, alu_en 1 cycle, R2=8'hA5.
// 5. ir=16'hA000 at pc=4 -> halted=1, pc=5, no req; start -> fetch at addr 8'h05.
// 6. rstz=0 in MEM -> next cycle dmem_req=0, IDLE, pc=PC_RESET; ir=16'hB000 -> illegal=1, pc+1, no alu_en.

Source files
------------

// File: rtl/mas8_seq_ctrl.sv
// rtl/mas8_seq_ctrl.sv - fetch/decode/execute sequencer for the 8-bit ALU/register-file block
module mas8_seq_ctrl #(
    parameter logic [7:0] PC_RESET = 8'h00,
    parameter logic [3:0] HALT_OP  = 4'b1010,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             start,
    output logic             imem_req,
    output logic [7:0]       imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_data,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [7:0]       dmem_addr,
    output logic [7:0]       dmem_wdata,
    input  logic             dmem_ack,
    input  logic [7:0]       dmem_rdata,
    output logic [3:0]       alu_opcode,
    output logic [1:0]       alu_rd,
    output logic [1:0]       alu_ra,
    output logic [7:0]       alu_c,
    output logic             alu_en,
    output logic [7:0]       alu_din,
    input  logic [7:0]       alu_radr,
    input  logic [7:0]       reg_q0,
    input  logic [7:0]       reg_q1,
    input  logic [7:0]       reg_q2,
    input  logic [7:0]       reg_q3,
    output logic [7:0]       pc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [7:0]       maddr_q, maddr_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       op;
    logic [7:0]       store_data;

    assign op = ir_q[15:12];

    // ALU fields follow ir continuously so alu_radr is valid in EXEC and MEM
    assign alu_opcode = ir_q[15:12];
    assign alu_rd     = ir_q[11:10];
    assign alu_ra     = ir_q[9:8];
    assign alu_c      = ir_q[7:0];
    assign alu_din    = dmem_rdata;

    assign imem_addr  = pc_q;
    assign dmem_addr  = maddr_q;
    assign dmem_we    = (op == 4'b1001);
    assign dmem_wdata = store_data;

    assign pc         = pc_q;
    assign illegal    = illegal_q;
    assign instr_cnt  = cnt_q;
    assign halted     = (state_q == S_HALTED);

    // Store data comes from the register addressed by ir.rd
    always_comb begin
        store_data = reg_q0;
        case (ir_q[11:10])
            2'd0:    store_data = reg_q0;
            2'd1:    store_data = reg_q1;
            2'd2:    store_data = reg_q2;
            default: store_data = reg_q3;
        endcase
    end

    // State and datapath registers; reset wins over any pending handshake
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= 16'h0000;
            maddr_q   <= 8'h00;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            maddr_q   <= maddr_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state, request and enable generation
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        maddr_d   = maddr_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        alu_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                // HALT_OP is checked first so it takes priority over any other decode
                if (op == HALT_OP) begin
                    pc_d    = pc_q + 8'd1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_HALTED;
                end else begin
                    case (op)
                        4'b0000, 4'b0001, 4'b0010, 4'b0011,
                        4'b0100, 4'b0101, 4'b0110, 4'b0111,
                        4'b1100, 4'b1101: begin
                            alu_en  = 1'b1;
                            pc_d    = pc_q + 8'd1;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = S_FETCH;
                        end
                        4'b1111: begin
                            pc_d    = alu_radr;
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = S_FETCH;
                        end
                        4'b1000, 4'b1001: begin
                            maddr_d = alu_radr;
                            state_d = S_MEM;
                        end
                        4'b1011, 4'b1110: begin
                            illegal_d = 1'b1;
                            pc_d      = pc_q + 8'd1;
                            state_d   = S_FETCH;
                        end
                        default: begin
                            // Opcode slot freed when HALT_OP is moved: skip it silently
                            pc_d    = pc_q + 8'd1;
                            state_d = S_FETCH;
                        end
                    endcase
                end
            end

            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    alu_en  = !dmem_we;
                    pc_d    = pc_q + 8'd1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                end
            end

            S_HALTED: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mas8_seq_ctrl.sv
// tb/tb_mas8_seq_ctrl.sv - scoreboard bench for mas8_seq_ctrl with memory and ALU models
module tb_mas8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rstz;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ack;
    logic [7:0]  dmem_rdata;
    logic [3:0]  alu_opcode;
    logic [1:0]  alu_rd;
    logic [1:0]  alu_ra;
    logic [7:0]  alu_c;
    logic        alu_en;
    logic [7:0]  alu_din;
    logic [7:0]  alu_radr;
    logic [7:0]  reg_q0, reg_q1, reg_q2, reg_q3;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_cnt;

    always #5 clk = ~clk;

    mas8_seq_ctrl dut (
        .clk        (clk),
        .rstz       (rstz),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .alu_opcode (alu_opcode),
        .alu_rd     (alu_rd),
        .alu_ra     (alu_ra),
        .alu_c      (alu_c),
        .alu_en     (alu_en),
        .alu_din    (alu_din),
        .alu_radr   (alu_radr),
        .reg_q0     (reg_q0),
        .reg_q1     (reg_q1),
        .reg_q2     (reg_q2),
        .reg_q3     (reg_q3),
        .pc         (pc),
        .halted     (halted),
        .illegal    (illegal),
        .instr_cnt  (instr_cnt)
    );

    // ALU / register-file model: ops write R[rd] = R[ra] + c, loads write din
    logic [7:0] regs [4];
    logic [7:0] alu_result;
    assign reg_q0     = regs[0];
    assign reg_q1     = regs[1];
    assign reg_q2     = regs[2];
    assign reg_q3     = regs[3];
    assign alu_radr   = regs[alu_ra] + alu_c;
    assign alu_result = (alu_opcode == 4'b1000) ? alu_din : alu_radr;

    always @(posedge clk) begin
        if (!rstz) begin
            for (int i = 0; i < 4; i++) regs[i] <= 8'h00;
        end else if (alu_en) begin
            regs[alu_rd] <= alu_result;
        end
    end

    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    int          imem_wait;
    int          dmem_wait_st;
    int          dmem_wait_ld;
    int          icnt;
    int          dcnt;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] q_fetch [$];
    logic [31:0] q_alu   [$];
    logic [31:0] q_dmem  [$];

    // Memory responders: ack after a programmable number of wait cycles
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (icnt >= imem_wait) begin
                imem_ack  = 1'b1;
                imem_data = imem[imem_addr];
                icnt      = 0;
            end else begin
                imem_ack = 1'b0;
                icnt++;
            end
        end else begin
            imem_ack = 1'b0;
            icnt     = 0;
        end
        if (dmem_req) begin
            if (dcnt >= (dmem_we ? dmem_wait_st : dmem_wait_ld)) begin
                dmem_ack   = 1'b1;
                dmem_rdata = dmem[dmem_addr];
                dcnt       = 0;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
            end else begin
                dmem_ack = 1'b0;
                dcnt++;
            end
        end else begin
            dmem_ack = 1'b0;
            dcnt     = 0;
        end
    end

    // Monitor: pop scoreboard entries on each completed transfer and ALU write
    logic        i_prev = 1'b0;
    logic        d_prev = 1'b0;
    int          dlen   = 0;
    logic [31:0] exp_v;

    always @(negedge clk) begin
        if (i_prev) check_eq("imem_req_after_ack", 32'(imem_req), 32'd0);
        if (d_prev) check_eq("dmem_req_after_ack", 32'(dmem_req), 32'd0);
        i_prev = imem_req && imem_ack;
        d_prev = dmem_req && dmem_ack;
        if (dmem_req) dlen++; else dlen = 0;

        if (imem_req && imem_ack) begin
            exp_v = (q_fetch.size() > 0) ? q_fetch.pop_front() : 32'hDEAD_0000;
            check_eq("fetch_addr", 32'(imem_addr), exp_v);
        end
        if (alu_en) begin
            exp_v = (q_alu.size() > 0) ? q_alu.pop_front() : 32'hDEAD_0001;
            check_eq("alu_write", 32'({alu_rd, alu_result}), exp_v);
        end
        if (dmem_req && dmem_ack) begin
            exp_v = (q_dmem.size() > 0) ? q_dmem.pop_front() : 32'hDEAD_0002;
            check_eq("dmem_xfer", {7'd0, dmem_we, dmem_addr, dmem_wdata, 8'(dlen)}, exp_v);
            dlen = 0;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check_eq(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rstz         = 1'b0;
        start        = 1'b0;
        imem_ack     = 1'b0;
        imem_data    = 16'h0000;
        dmem_ack     = 1'b0;
        dmem_rdata   = 8'h00;
        imem_wait    = 0;
        dmem_wait_st = 3;
        dmem_wait_ld = 0;
        icnt         = 0;
        dcnt         = 0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hA000;
            dmem[i] = 8'h00;
        end
        dmem[8'h08] = 8'hA5;
        imem[8'h00] = 16'h0005;
        imem[8'h01] = 16'h0507;
        imem[8'h02] = 16'hF010;
        imem[8'h15] = 16'h9402;
        imem[8'h16] = 16'h8803;
        imem[8'h17] = 16'hB000;
        imem[8'h18] = 16'hA000;
        imem[8'h19] = 16'hF0FA;
        imem[8'hFF] = 16'hA000;
        imem[8'h04] = 16'hA000;
        imem[8'h05] = 16'h8803;

        repeat (3) @(posedge clk);
        #1 rstz = 1'b1;
        @(negedge clk);
        check_eq("rst_pc",       32'(pc),        32'h00);
        check_eq("rst_cnt",      32'(instr_cnt), 32'd0);
        check_eq("rst_illegal",  32'(illegal),   32'd0);
        check_eq("rst_halted",   32'(halted),    32'd0);
        check_eq("rst_imem_req", 32'(imem_req),  32'd0);
        check_eq("rst_dmem_req", 32'(dmem_req),  32'd0);
        check_eq("rst_alu_en",   32'(alu_en),    32'd0);

        // ALU ops, jump, store with waits, load, illegal, halt
        q_fetch.push_back(32'h00); q_fetch.push_back(32'h01); q_fetch.push_back(32'h02);
        q_fetch.push_back(32'h15); q_fetch.push_back(32'h16); q_fetch.push_back(32'h17);
        q_fetch.push_back(32'h18);
        q_alu.push_back(32'h005); q_alu.push_back(32'h107); q_alu.push_back(32'h2A5);
        q_dmem.push_back({7'd0, 1'b1, 8'h07, 8'h07, 8'd4});
        q_dmem.push_back({7'd0, 1'b0, 8'h08, 8'h00, 8'd1});
        pulse_start();
        wait_halt(200, "halt_a");
        check_eq("a_pc",      32'(pc),        32'h19);
        check_eq("a_cnt",     32'(instr_cnt), 32'd6);
        check_eq("a_illegal", 32'(illegal),   32'd1);
        check_eq("a_r0",      32'(regs[0]),   32'h05);
        check_eq("a_r1",      32'(regs[1]),   32'h07);
        check_eq("a_r2",      32'(regs[2]),   32'hA5);
        check_eq("a_stored",  32'(dmem[8'h07]), 32'h07);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("halt_no_ireq", 32'(imem_req), 32'd0);
            check_eq("halt_no_dreq", 32'(dmem_req), 32'd0);
        end

        // Jump to 0xFF then halt there: pc wraps to 0
        q_fetch.push_back(32'h19); q_fetch.push_back(32'hFF);
        pulse_start();
        wait_halt(100, "halt_b");
        check_eq("b_pc_wrap", 32'(pc),        32'h00);
        check_eq("b_cnt",     32'(instr_cnt), 32'd8);

        // Jump with address wrap (5 + 0xFF = 0x04), halt at 4, resume at 5
        imem[8'h00] = 16'hF0FF;
        q_fetch.push_back(32'h00); q_fetch.push_back(32'h04);
        pulse_start();
        wait_halt(100, "halt_c");
        check_eq("c_pc",  32'(pc),        32'h05);
        check_eq("c_cnt", 32'(instr_cnt), 32'd10);

        // Load stalled in MEM, stray start ignored, then reset mid-handshake
        dmem_wait_ld = 50;
        q_fetch.push_back(32'h05);
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dmem_req) break;
        end
        check_eq("d_in_mem", 32'(dmem_req), 32'd1);
        pulse_start();
        @(negedge clk);
        check_eq("d_start_ignored", 32'(dmem_req), 32'd1);
        check_eq("d_addr",          32'(dmem_addr), 32'h08);
        check_eq("d_we",            32'(dmem_we),   32'd0);
        @(posedge clk); #1 rstz = 1'b0;
        @(posedge clk); #1 rstz = 1'b1;
        @(negedge clk);
        check_eq("d_rst_dreq",    32'(dmem_req),  32'd0);
        check_eq("d_rst_ireq",    32'(imem_req),  32'd0);
        check_eq("d_rst_pc",      32'(pc),        32'h00);
        check_eq("d_rst_cnt",     32'(instr_cnt), 32'd0);
        check_eq("d_rst_illegal", 32'(illegal),   32'd0);
        check_eq("d_rst_halted",  32'(halted),    32'd0);

        check_eq("fetch_q_left", 32'(q_fetch.size()), 32'd0);
        check_eq("alu_q_left",   32'(q_alu.size()),   32'd0);
        check_eq("dmem_q_left",  32'(q_dmem.size()),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
